// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU: single-cycle logic/add/sub/slt plus iterative
// shift-add multiply and restoring divide behind a valid/ready handshake.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       ALUCtrl_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             Zero_o,
    output logic             Ovf_o,
    output logic             Div0_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg, op_next;
    logic [WIDTH-1:0]   opa_reg, opa_next;    // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   opb_reg, opb_next;    // multiplier, or divisor
    logic [WIDTH-1:0]   acc_reg, acc_next;    // product, or partial remainder
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               pend_div0_reg, pend_div0_next;

    logic [WIDTH-1:0]   data_reg, data_next;
    logic               valid_reg, valid_next;
    logic               zero_reg, zero_next;
    logic               ovf_reg, ovf_next;
    logic               div0_reg, div0_next;

    logic [WIDTH-1:0]   add_res, sub_res, single_res, single_ovf_res;
    logic               add_ovf, sub_ovf, single_ovf;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_ge;
    logic [WIDTH-1:0]   acc_step, opa_step, opb_step, iter_res;

    // Single-cycle datapath straight from the request operands
    always_comb begin
        add_res    = data1_i + data2_i;
        sub_res    = data1_i - data2_i;
        add_ovf    = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (add_res[WIDTH-1] != data1_i[WIDTH-1]);
        sub_ovf    = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (sub_res[WIDTH-1] != data1_i[WIDTH-1]);
        single_res = '0;
        single_ovf = 1'b0;
        single_ovf_res = '0;
        case (ALUCtrl_i)
            OP_AND: single_res = data1_i & data2_i;
            OP_OR:  single_res = data1_i | data2_i;
            OP_ADD: begin
                single_res = add_res;
                single_ovf = add_ovf;
            end
            OP_SUB: begin
                single_res = sub_res;
                single_ovf = sub_ovf;
            end
            OP_SLT: single_res = {{(WIDTH-1){1'b0}}, sub_res[WIDTH-1] ^ sub_ovf};
            default: single_res = '0;
        endcase
    end

    // One multiply or divide iteration on the latched operands
    always_comb begin
        rem_shift = {acc_reg, opa_reg[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, opb_reg};
        rem_diff  = rem_shift[WIDTH-1:0] - opb_reg;
        if (op_reg == OP_MUL) begin
            acc_step = opb_reg[0] ? (acc_reg + opa_reg) : acc_reg;
            opa_step = opa_reg << 1;
            opb_step = opb_reg >> 1;
        end else begin
            acc_step = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
            opa_step = {opa_reg[WIDTH-2:0], rem_ge};
            opb_step = opb_reg;
        end
        iter_res = (op_reg == OP_DIVU) ? opa_step : acc_step;
    end

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        opa_next       = opa_reg;
        opb_next       = opb_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        pend_div0_next = pend_div0_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        zero_next      = zero_reg;
        ovf_next       = ovf_reg;
        div0_next      = div0_reg;
        case (state_reg)
            IDLE: begin
                if (valid_i) begin
                    if (ALUCtrl_i == OP_MUL || ALUCtrl_i == OP_DIVU || ALUCtrl_i == OP_REMU) begin
                        state_next     = BUSY;
                        op_next        = ALUCtrl_i;
                        opa_next       = data1_i;
                        opb_next       = data2_i;
                        acc_next       = '0;
                        cnt_next       = '0;
                        pend_div0_next = (ALUCtrl_i != OP_MUL) && (data2_i == '0);
                    end else begin
                        data_next  = single_res;
                        valid_next = 1'b1;
                        zero_next  = (single_res == '0);
                        ovf_next   = single_ovf;
                        div0_next  = 1'b0;
                    end
                end
            end
            BUSY: begin
                opa_next = opa_step;
                opb_next = opb_step;
                acc_next = acc_step;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = IDLE;
                    data_next  = iter_res;
                    valid_next = 1'b1;
                    zero_next  = (iter_res == '0);
                    ovf_next   = 1'b0;
                    div0_next  = pend_div0_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            op_reg        <= OP_AND;
            opa_reg       <= '0;
            opb_reg       <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            pend_div0_reg <= 1'b0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            zero_reg      <= 1'b1;
            ovf_reg       <= 1'b0;
            div0_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            opa_reg       <= opa_next;
            opb_reg       <= opb_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            pend_div0_reg <= pend_div0_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            zero_reg      <= zero_next;
            ovf_reg       <= ovf_next;
            div0_reg      <= div0_next;
        end
    end

    assign ready_o = (state_reg == IDLE);
    assign data_o  = data_reg;
    assign valid_o = valid_reg;
    assign Zero_o  = zero_reg;
    assign Ovf_o   = ovf_reg;
    assign Div0_o  = div0_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table on a 32-bit instance plus
// hand sequences for back-to-back issue, busy stalls, reset abort and WIDTH=8.
module tb_alu_multicycle;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        valid32, ready32, ovalid32, zero32, ovf32, div032;
    logic [31:0] a32, b32, d32;
    logic [2:0]  ctrl32;

    logic        valid8, ready8, ovalid8, zero8, ovf8, div08;
    logic [7:0]  a8, b8, d8;
    logic [2:0]  ctrl8;

    alu_multicycle #(.WIDTH(32)) u32 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid32), .ready_o(ready32),
        .data1_i(a32), .data2_i(b32), .ALUCtrl_i(ctrl32), .data_o(d32),
        .valid_o(ovalid32), .Zero_o(zero32), .Ovf_o(ovf32), .Div0_o(div032)
    );

    alu_multicycle #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid8), .ready_o(ready8),
        .data1_i(a8), .data2_i(b8), .ALUCtrl_i(ctrl8), .data_o(d8),
        .valid_o(ovalid8), .Zero_o(zero8), .Ovf_o(ovf8), .Div0_o(div08)
    );

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_z;
        logic        exp_ovf;
        logic        exp_div0;
        int          exp_lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input vec_t v, input int idx);
        int lat;
        check($sformatf("vec%0d ready", idx), ready32, 1);
        ctrl32  = v.ctrl;
        a32     = v.a;
        b32     = v.b;
        valid32 = 1'b1;
        tick();
        valid32 = 1'b0;
        a32     = $urandom;
        b32     = $urandom;
        ctrl32  = 3'($urandom);
        lat = 1;
        while (!ovalid32 && lat < 100) begin
            tick();
            lat++;
        end
        check($sformatf("vec%0d latency", idx), lat, v.exp_lat);
        check($sformatf("vec%0d data", idx), d32, v.exp_d);
        check($sformatf("vec%0d zero", idx), zero32, v.exp_z);
        check($sformatf("vec%0d ovf", idx), ovf32, v.exp_ovf);
        check($sformatf("vec%0d div0", idx), div032, v.exp_div0);
        $display("vec%0d op=%0d a=0x%08h b=0x%08h -> data=0x%08h z=%0d o=%0d d0=%0d lat=%0d",
                 idx, v.ctrl, v.a, v.b, d32, zero32, ovf32, div032, lat);
    endtask

    task automatic run8(input string name, input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_z, input logic exp_ovf,
                        input logic exp_div0, input int exp_lat);
        int lat;
        ctrl8  = c;
        a8     = a;
        b8     = b;
        valid8 = 1'b1;
        tick();
        valid8 = 1'b0;
        lat = 1;
        while (!ovalid8 && lat < 100) begin
            tick();
            lat++;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " data"}, d8, exp_d);
        check({name, " zero"}, zero8, exp_z);
        check({name, " ovf"}, ovf8, exp_ovf);
        check({name, " div0"}, div08, exp_div0);
        $display("%s: data=0x%02h z=%0d o=%0d d0=%0d lat=%0d", name, d8, zero8, ovf8, div08, lat);
    endtask

    vec_t vecs[18];

    initial begin
        int cnt;
        int ready_low;
        int pulses;

        vecs[0]  = '{3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1};
        vecs[4]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[5]  = '{3'b111, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{3'b011, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, 1'b0, 1'b0, 33};
        vecs[10] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 33};
        vecs[11] = '{3'b100, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1'b0, 33};
        vecs[12] = '{3'b101, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0, 33};
        vecs[13] = '{3'b100, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 33};
        vecs[14] = '{3'b101, 32'd9,         32'd0,         32'd9,         1'b0, 1'b0, 1'b1, 33};
        vecs[15] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0, 33};
        vecs[16] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 33};
        vecs[17] = '{3'b100, 32'd3,         32'd5,         32'd0,         1'b1, 1'b0, 1'b0, 33};

        rst_n = 1'b1; valid32 = 1'b0; a32 = '0; b32 = '0; ctrl32 = '0;
        valid8 = 1'b0; a8 = '0; b8 = '0; ctrl8 = '0;

        // Asynchronous reset with no clock edge in between
        #2 rst_n = 1'b0;
        #1;
        check("reset ready", ready32, 1);
        check("reset valid", ovalid32, 0);
        check("reset data", d32, 0);
        check("reset zero", zero32, 1);
        $display("reset: ready=%0d valid=%0d data=0x%08h zero=%0d", ready32, ovalid32, d32, zero32);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) run32(vecs[i], i);

        // Back-to-back single-cycle ops on consecutive edges
        tick();
        ctrl32 = 3'b010; a32 = 32'h7FFF_FFFF; b32 = 32'h1; valid32 = 1'b1;
        tick();
        check("b2b add valid", ovalid32, 1); check("b2b add data", d32, 32'h8000_0000); check("b2b add ovf", ovf32, 1);
        $display("b2b ADD: data=0x%08h ovf=%0d", d32, ovf32);
        ctrl32 = 3'b110; a32 = 32'd5; b32 = 32'd5;
        tick();
        check("b2b sub valid", ovalid32, 1); check("b2b sub data", d32, 0); check("b2b sub zero", zero32, 1);
        $display("b2b SUB: data=0x%08h zero=%0d", d32, zero32);
        ctrl32 = 3'b111; a32 = 32'hFFFF_FFFF; b32 = 32'd1;
        tick();
        check("b2b slt valid", ovalid32, 1); check("b2b slt data", d32, 1); check("b2b slt ovf", ovf32, 0);
        $display("b2b SLT: data=0x%08h", d32);
        ctrl32 = 3'b001; a32 = 32'hF0; b32 = 32'h0F;
        tick();
        check("b2b or valid", ovalid32, 1); check("b2b or data", d32, 32'hFF);
        $display("b2b OR: data=0x%08h", d32);
        valid32 = 1'b0;
        tick();
        check("b2b idle valid", ovalid32, 0); check("b2b hold data", d32, 32'hFF);

        // MUL with valid_i held high during BUSY carrying other operands
        ctrl32 = 3'b011; a32 = 32'h0001_0003; b32 = 32'h5; valid32 = 1'b1;
        tick();
        ctrl32 = 3'b010; a32 = 32'd1; b32 = 32'd1;
        ready_low = 0;
        pulses = 0;
        for (int k = 1; k <= 33; k++) begin
            if (k <= 32 && !ready32) ready_low++;
            if (k <= 32 && ovalid32) pulses++;
            if (k < 33) tick();
        end
        check("mul stall ready low cycles", ready_low, 32);
        check("mul stall early valid", pulses, 0);
        check("mul stall valid at 33", ovalid32, 1);
        check("mul stall data", d32, 32'h0005_000F);
        valid32 = 1'b0;
        $display("MUL stall: data=0x%08h ready_low=%0d", d32, ready_low);
        tick();
        check("mul stall no extra valid", ovalid32, 0);

        // DIVU then REMU accepted in the cycle valid_o pulses
        ctrl32 = 3'b100; a32 = 32'd100; b32 = 32'd7; valid32 = 1'b1;
        tick();
        valid32 = 1'b0;
        cnt = 1;
        while (!ovalid32 && cnt < 100) begin tick(); cnt++; end
        check("divu latency", cnt, 33); check("divu data", d32, 14); check("divu ready", ready32, 1);
        $display("DIVU 100/7: data=%0d lat=%0d", d32, cnt);
        ctrl32 = 3'b101; a32 = 32'd100; b32 = 32'd7; valid32 = 1'b1;
        tick();
        valid32 = 1'b0;
        check("remu accepted", ready32, 0);
        cnt = 1;
        while (!ovalid32 && cnt < 100) begin tick(); cnt++; end
        check("remu latency", cnt, 33); check("remu data", d32, 2);
        $display("REMU 100/7: data=%0d lat=%0d", d32, cnt);

        // Reset in the middle of a MUL
        ctrl32 = 3'b011; a32 = 32'h0001_0003; b32 = 32'h5; valid32 = 1'b1;
        tick();
        valid32 = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        #1 rst_n = 1'b0;
        #1;
        check("midrst ready", ready32, 1); check("midrst valid", ovalid32, 0);
        check("midrst data", d32, 0); check("midrst zero", zero32, 1);
        #1 rst_n = 1'b1;
        ctrl32 = 3'b010; a32 = 32'd2; b32 = 32'd3; valid32 = 1'b1;
        tick();
        valid32 = 1'b0;
        check("midrst add valid", ovalid32, 1); check("midrst add data", d32, 5);
        $display("reset mid-MUL then ADD 2+3: data=%0d", d32);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin tick(); if (ovalid32) pulses++; end
        check("midrst stale valid", pulses, 0);

        // WIDTH=8 instance
        run8("w8 MUL 0x10*0x10", 3'b011, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 9);
        run8("w8 SLT 0x80<0x7F", 3'b111, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1);
        run8("w8 ADD 0x7F+1",    3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1);
        run8("w8 MUL 0x0D*0x0B", 3'b011, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b0, 9);
        run8("w8 DIVU 0xFF/0",   3'b100, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 9);
        run8("w8 REMU 200/9",    3'b101, 8'd200, 8'd9, 8'd2,  1'b0, 1'b0, 1'b0, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds iterative unsigned multiply, divide and remainder alongside AND/OR/ADD/SUB/SLT, with a valid/ready handshake so the pipeline can stall on long operations.
- Also registers the zero and signed-overflow flags.
- Sits in EX stage. The hazard unit stalls on ready_o low and consumes the result on valid_o.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; not to be overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- valid_i  input  1  operation request.
- ready_o  output  1  block can accept a request this cycle.
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B.
- ALUCtrl_i  input  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 011 MUL (low WIDTH bits, unsigned), 100 DIVU quotient, 101 REMU remainder.
- data_o  output  WIDTH  registered result.
- valid_o  output  1  one-cycle pulse: data_o/flags just updated.
- Zero_o  output  1  data_o == 0, registered with data_o.
- Ovf_o  output  1  signed overflow (ADD/SUB only, else 0).
- Div0_o  output  1  DIVU/REMU with data2_i == 0, else 0.

Behaviour:
- Reset values (rst_i low, asynchronous): state IDLE, ready_o=1, valid_o=0, data_o=0, Zero_o=1, Ovf_o=0, Div0_o=0, counter=0.
- Reset mid-operation aborts the operation. No valid_o is produced for it.
- Accept rule: a request is taken on the rising edge where valid_i && ready_o. Inputs are sampled only at that edge, so operands may change afterwards.
- FSM has two states, IDLE and BUSY.
- ready_o = (state == IDLE).
- valid_i while BUSY is ignored; no queueing.
- Single-cycle ops (AND/OR/ADD/SUB/SLT):
  - At the accept edge, data_o and all flags are loaded and valid_o=1 for the following cycle.
  - State stays IDLE, so back-to-back accepts are allowed every cycle. valid_o stays high on consecutive accepts.
- ADD/SUB:
  - Wrap modulo 2^WIDTH.
  - Ovf_o = operands' signs (B inverted for SUB) equal and result sign differs.
- SLT: result = 1 if A < B signed, else 0. Computed as sub_msb XOR sub_overflow. Ovf_o=0.
- Multi-cycle ops (MUL/DIVU/REMU):
  - At the accept edge: go to BUSY, latch operands, clear accumulator/remainder, counter=0.
  - One iteration per cycle, WIDTH iterations.
  - MUL is LSB-first shift-add, keeping the low WIDTH bits.
  - DIVU/REMU is restoring division, MSB-first.
  - On the edge completing iteration WIDTH: load data_o/flags, pulse valid_o, return to IDLE.
  - Latency: valid_o is high exactly WIDTH+1 cycles after the accept cycle. ready_o is low for WIDTH cycles.
  - A new request may be accepted in the cycle valid_o is high.
- Divide by zero:
  - No special path; the restoring divider yields quotient = all ones and remainder = dividend.
  - Div0_o=1. It still takes WIDTH cycles.
- Between results: data_o and flags hold their last values. valid_o is 0 when no result lands on the preceding edge.
- Zero_o always reflects the registered data_o, including SLT=0 and divide results.

Test Plan:
- Reset: assert rst_i low mid-cycle with no clock edge -> ready_o=1, valid_o=0, data_o=0, Zero_o=1 immediately.
- Single-cycle ops: back-to-back ADD 0x7FFFFFFF+1, SUB 5-5, SLT 0xFFFFFFFF vs 1, OR 0xF0|0x0F on consecutive cycles.
  - Expected: 0x80000000 with Ovf_o=1; 0 with Zero_o=1; 1; 0xFF.
  - valid_o high for 4 consecutive cycles.
- MUL 0x0001_0003 * 0x0000_0005:
  - valid_o exactly 33 cycles after accept, data_o=0x0005_000F.
  - ready_o low 32 cycles.
  - valid_i held high during BUSY with other operands is ignored.
- DIVU 100/7 -> 14, then REMU 100/7 -> 2, the second accepted in the same cycle valid_o pulses for the first.
  - Then DIVU 9/0 -> 0xFFFFFFFF with Div0_o=1, and REMU 9/0 -> 9.
- Reset mid-MUL: pull rst_i low at iteration 10, release, issue ADD 2+3 -> no stale valid_o; next result 5 one cycle after accept.
- WIDTH=8 instance: MUL 0x10*0x10 -> 0x00, Zero_o=1, latency 9 cycles; SLT 0x80 vs 0x7F -> 1.
